sd_spi_sclk_gen: RTL and testbench

- Parametrised SPI clock generator for the SD card interface. It produces a real SCLK waveform rather than bare ticks.
- Also produces single-cycle leading/trailing edge strobes that the byte-transfer logic uses for sampling and shifting.
- Holds two runtime-programmable dividers (init ~400 kHz, normal ~35 MHz) and switches between them glitch-free, only at an idle-level boundary.
- Sits between the 210 MHz clock domain and the SD card SPI transfer engine.

---
 rtl/sd_spi_sclk_gen.sv | 187 ++++++++++++++++++
 tb/tb_sd_spi_sclk_gen.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_sclk_gen.sv
// SPI SCLK generator for the SD card interface.
// Produces the SCLK waveform plus single-cycle leading/trailing edge strobes
// for the byte-transfer engine. Two runtime-programmable dividers (init and
// normal) are held here. The divider in effect and the run/stop decision are
// only re-evaluated with SCLK at its idle level, so no phase is ever shortened.
module sd_spi_sclk_gen #(
   parameter int unsigned CNT_W              = 16,
   parameter int unsigned INIT_DIV_DEFAULT   = 262,
   parameter int unsigned NORMAL_DIV_DEFAULT = 2,
   parameter bit          CPOL               = 1'b0,
   parameter int unsigned CYC_W              = 8
) (
   input  logic             clk210_p,
   input  logic             reset_p,
   input  logic             enable_p,
   input  logic             mode_sel_p,
   input  logic             div_load_p,
   input  logic             div_target_p,
   input  logic [CNT_W-1:0] div_value_p,
   output logic             sclk_p,
   output logic             lead_tick_p,
   output logic             trail_tick_p,
   output logic             busy_p,
   output logic             mode_active_p,
   output logic [CYC_W-1:0] cycle_cnt_p
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] INIT_RST = CNT_W'(INIT_DIV_DEFAULT);
   localparam logic [CNT_W-1:0] NORM_RST = CNT_W'(NORMAL_DIV_DEFAULT);
   localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;

   logic [CNT_W-1:0] r_init_div;
   logic [CNT_W-1:0] r_norm_div;
   logic [CNT_W-1:0] r_active_div;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sclk;
   logic             r_lead;
   logic             r_trail;
   logic             r_busy;
   logic             r_mode;
   logic [CYC_W-1:0] r_cyc;

   logic [CNT_W-1:0] w_load_val;
   logic [CNT_W-1:0] w_sel_div;
   logic             w_hit;
   logic             w_lead_edge;
   logic             w_trail_edge;
   logic             w_start;
   logic             w_latch;

   // Clamp loaded divider values and pick the divider for the next latch point,
   // forwarding a load that lands in the same cycle as the latch.
   always_comb begin
      w_load_val = (div_value_p == '0) ? DIV_MIN : div_value_p;
      w_sel_div  = mode_sel_p ? r_norm_div : r_init_div;
      if (div_load_p && (div_target_p == mode_sel_p)) begin
         w_sel_div = w_load_val;
      end
   end

   // Half-period expiry and the SCLK edge it produces on the next clock.
   always_comb begin
      w_hit        = (r_state == ST_RUN) && (r_cnt == r_active_div);
      w_lead_edge  = w_hit && (r_sclk == CPOL);
      w_trail_edge = w_hit && (r_sclk != CPOL);
      w_start      = (r_state == ST_IDLE) && enable_p;
      w_latch      = w_start || w_trail_edge;
   end

   // Next-state logic: enable is only honoured at idle-level boundaries.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (enable_p) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_trail_edge && !enable_p) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register and busy flag, which mirrors the RUN state.
   always_ff @(posedge clk210_p or posedge reset_p) begin
      if (reset_p) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_RUN);
      end
   end

   // Programmable divider registers; zero is stored as one.
   always_ff @(posedge clk210_p or posedge reset_p) begin
      if (reset_p) begin
         r_init_div <= INIT_RST;
         r_norm_div <= NORM_RST;
      end else if (div_load_p) begin
         if (div_target_p) begin
            r_norm_div <= w_load_val;
         end else begin
            r_init_div <= w_load_val;
         end
      end
   end

   // Divider and mode in effect, updated only at latch points.
   always_ff @(posedge clk210_p or posedge reset_p) begin
      if (reset_p) begin
         r_active_div <= INIT_RST;
         r_mode       <= 1'b0;
      end else if (w_latch) begin
         r_active_div <= w_sel_div;
         r_mode       <= mode_sel_p;
      end
   end

   // Half-period counter: runs in RUN, wraps on expiry, held at zero in IDLE.
   always_ff @(posedge clk210_p or posedge reset_p) begin
      if (reset_p) begin
         r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
         if (w_hit) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else begin
         r_cnt <= '0;
      end
   end

   // SCLK flop: toggles on half-period expiry, parked at idle level in IDLE.
   always_ff @(posedge clk210_p or posedge reset_p) begin
      if (reset_p) begin
         r_sclk <= CPOL;
      end else if (r_state == ST_IDLE) begin
         r_sclk <= CPOL;
      end else if (w_hit) begin
         r_sclk <= ~r_sclk;
      end
   end

   // Edge strobes, registered so they coincide with the new SCLK level.
   always_ff @(posedge clk210_p or posedge reset_p) begin
      if (reset_p) begin
         r_lead  <= 1'b0;
         r_trail <= 1'b0;
      end else begin
         r_lead  <= w_lead_edge;
         r_trail <= w_trail_edge;
      end
   end

   // Completed-cycle counter: cleared on leaving IDLE, saturates at all-ones.
   always_ff @(posedge clk210_p or posedge reset_p) begin
      if (reset_p) begin
         r_cyc <= '0;
      end else if (w_start) begin
         r_cyc <= '0;
      end else if (w_trail_edge && (r_cyc != '1)) begin
         r_cyc <= r_cyc + 1'b1;
      end
   end

   assign sclk_p        = r_sclk;
   assign lead_tick_p   = r_lead;
   assign trail_tick_p  = r_trail;
   assign busy_p        = r_busy;
   assign mode_active_p = r_mode;
   assign cycle_cnt_p   = r_cyc;

endmodule

// File: tb/tb_sd_spi_sclk_gen.sv
// Self-checking bench for sd_spi_sclk_gen. The reference model schedules SCLK
// edges by absolute clock-edge deadlines derived from the divider rules.
module tb_sd_spi_sclk_gen;

   localparam int unsigned CNT_W    = 16;
   localparam int unsigned INIT_DIV = 262;
   localparam int unsigned NORM_DIV = 2;
   localparam bit          CPOL     = 1'b0;
   localparam int unsigned CYC_W    = 8;
   localparam int unsigned CYC_MAX  = (1 << CYC_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en  = 1'b0;
   logic             sel = 1'b0;
   logic             ld  = 1'b0;
   logic             tgt = 1'b0;
   logic [CNT_W-1:0] val = '0;
   logic             sclk, lead, trail, busy, mode;
   logic [CYC_W-1:0] cyc;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // reference model state
   int unsigned n = 0;
   bit          m_run, m_level, m_lead, m_trail, m_mode;
   int unsigned m_cyc, m_div, m_next, m_init, m_norm;

   always #5 clk = ~clk;

   sd_spi_sclk_gen #(
      .CNT_W              (CNT_W),
      .INIT_DIV_DEFAULT   (INIT_DIV),
      .NORMAL_DIV_DEFAULT (NORM_DIV),
      .CPOL               (CPOL),
      .CYC_W              (CYC_W)
   ) dut (
      .clk210_p      (clk),
      .reset_p       (rst),
      .enable_p      (en),
      .mode_sel_p    (sel),
      .div_load_p    (ld),
      .div_target_p  (tgt),
      .div_value_p   (val),
      .sclk_p        (sclk),
      .lead_tick_p   (lead),
      .trail_tick_p  (trail),
      .busy_p        (busy),
      .mode_active_p (mode),
      .cycle_cnt_p   (cyc)
   );

   function automatic void model_reset();
      m_run = 0; m_level = CPOL; m_lead = 0; m_trail = 0; m_mode = 0;
      m_cyc = 0; m_init = INIT_DIV; m_norm = NORM_DIV; m_div = INIT_DIV; m_next = 0;
   endfunction

   function automatic void model_latch();
      int unsigned eff;
      if (ld && (tgt == sel)) eff = (val == 0) ? 1 : int'(val);
      else                    eff = sel ? m_norm : m_init;
      m_div  = eff;
      m_mode = sel;
      m_next = n + eff + 1;
   endfunction

   // One clock edge of the model, using the inputs held across that edge.
   function automatic void model_edge();
      n++;
      m_lead  = 0;
      m_trail = 0;
      if (!m_run) begin
         if (en) begin
            m_run = 1;
            m_cyc = 0;
            model_latch();
         end
      end else if (n == m_next) begin
         m_level = !m_level;
         if (m_level != CPOL) begin
            m_lead = 1;
            m_next = n + m_div + 1;
         end else begin
            m_trail = 1;
            if (m_cyc < CYC_MAX) m_cyc++;
            model_latch();
            if (!en) m_run = 0;
         end
      end
      if (ld) begin
         if (tgt) m_norm = (val == 0) ? 1 : int'(val);
         else     m_init = (val == 0) ? 1 : int'(val);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({sclk, lead, trail, busy, mode, cyc} !== {CPOL, 1'b0, 1'b0, 1'b0, 1'b0, CYC_W'(0)}) begin
         errors++;
         $display("FAIL reset_state: sclk/lead/trail/busy/mode/cyc got %b/%b/%b/%b/%b/%0d required %b/0/0/0/0/0",
                  sclk, lead, trail, busy, mode, cyc, CPOL);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if ({sclk, lead, trail, busy, mode, cyc} !== {m_level, m_lead, m_trail, m_run, m_mode, CYC_W'(m_cyc)}) begin
            errors++;
            $display("FAIL idle_after_reset edge %0d: got %b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
                     n, sclk, lead, trail, busy, mode, cyc, m_level, m_lead, m_trail, m_run, m_mode, m_cyc);
         end
      end
   endtask

   task automatic test_init_mode();
      int last;
      en = 1'b1; sel = 1'b0;
      last = int'(n) + 1;
      for (int i = 0; i < 1200; i++) begin
         step();
         checks++;
         if ({sclk, lead, trail, busy, mode, cyc} !== {m_level, m_lead, m_trail, m_run, m_mode, CYC_W'(m_cyc)}) begin
            errors++;
            $display("FAIL init_mode edge %0d: got %b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
                     n, sclk, lead, trail, busy, mode, cyc, m_level, m_lead, m_trail, m_run, m_mode, m_cyc);
         end
         if (lead || trail) begin
            checks++;
            if (int'(n) - last != int'(INIT_DIV) + 1) begin
               errors++;
               $display("FAIL init_tick_gap edge %0d: got %0d required %0d", n, int'(n) - last, INIT_DIV + 1);
            end
            last = int'(n);
         end
      end
   endtask

   task automatic test_mode_switch();
      bit found;
      int last;
      found = 0;
      for (int i = 0; i < 600 && !found; i++) begin
         step();
         checks++;
         if ({sclk, lead, trail, busy, mode, cyc} !== {m_level, m_lead, m_trail, m_run, m_mode, CYC_W'(m_cyc)}) begin
            errors++;
            $display("FAIL switch_wait edge %0d: got %b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
                     n, sclk, lead, trail, busy, mode, cyc, m_level, m_lead, m_trail, m_run, m_mode, m_cyc);
         end
         if (lead) found = 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL switch_lead_timeout: got none required lead tick"); end
      for (int i = 0; i < 50; i++) step();
      sel = 1'b1;
      found = 0;
      last = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         step();
         checks++;
         if ({sclk, lead, trail, busy, mode, cyc} !== {m_level, m_lead, m_trail, m_run, m_mode, CYC_W'(m_cyc)}) begin
            errors++;
            $display("FAIL switch_high_phase edge %0d: got %b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
                     n, sclk, lead, trail, busy, mode, cyc, m_level, m_lead, m_trail, m_run, m_mode, m_cyc);
         end
         if (trail) begin found = 1; last = int'(n); end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL switch_trail_timeout: got none required trail tick"); end
      for (int i = 0; i < 30; i++) begin
         step();
         checks++;
         if ({sclk, lead, trail, busy, mode, cyc} !== {m_level, m_lead, m_trail, m_run, m_mode, CYC_W'(m_cyc)}) begin
            errors++;
            $display("FAIL switch_normal edge %0d: got %b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
                     n, sclk, lead, trail, busy, mode, cyc, m_level, m_lead, m_trail, m_run, m_mode, m_cyc);
         end
         if (lead || trail) begin
            checks++;
            if (int'(n) - last != int'(NORM_DIV) + 1) begin
               errors++;
               $display("FAIL normal_tick_gap edge %0d: got %0d required %0d", n, int'(n) - last, NORM_DIV + 1);
            end
            last = int'(n);
         end
      end
   endtask

   task automatic test_div_load_zero();
      bit found;
      int last;
      ld = 1'b1; tgt = 1'b1; val = '0;
      step();
      ld = 1'b0;
      found = 0;
      last = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (trail) begin found = 1; last = int'(n); end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL load_zero_trail_timeout: got none required trail tick"); end
      for (int i = 0; i < 24; i++) begin
         step();
         checks++;
         if ({sclk, lead, trail, busy, mode, cyc} !== {m_level, m_lead, m_trail, m_run, m_mode, CYC_W'(m_cyc)}) begin
            errors++;
            $display("FAIL load_zero edge %0d: got %b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
                     n, sclk, lead, trail, busy, mode, cyc, m_level, m_lead, m_trail, m_run, m_mode, m_cyc);
         end
         if (lead || trail) begin
            checks++;
            if (int'(n) - last != 2) begin
               errors++;
               $display("FAIL load_zero_tick_gap edge %0d: got %0d required 2", n, int'(n) - last);
            end
            last = int'(n);
         end
      end
   endtask

   task automatic test_disable();
      bit found;
      int trails;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         if (lead) found = 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL disable_lead_timeout: got none required lead tick"); end
      step();
      en = 1'b0;
      trails = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if ({sclk, lead, trail, busy, mode, cyc} !== {m_level, m_lead, m_trail, m_run, m_mode, CYC_W'(m_cyc)}) begin
            errors++;
            $display("FAIL disable edge %0d: got %b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
                     n, sclk, lead, trail, busy, mode, cyc, m_level, m_lead, m_trail, m_run, m_mode, m_cyc);
         end
         if (trail) trails++;
      end
      checks++;
      if ({trails, busy, sclk} !== {32'd1, 1'b0, CPOL}) begin
         errors++;
         $display("FAIL disable_final: trails/busy/sclk got %0d/%b/%b required 1/0/%b", trails, busy, sclk, CPOL);
      end
   endtask

   task automatic test_saturation();
      bit found;
      en = 1'b1; sel = 1'b1;
      for (int i = 0; i < 1250; i++) begin
         step();
         checks++;
         if ({sclk, lead, trail, busy, mode, cyc} !== {m_level, m_lead, m_trail, m_run, m_mode, CYC_W'(m_cyc)}) begin
            errors++;
            $display("FAIL saturation edge %0d: got %b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
                     n, sclk, lead, trail, busy, mode, cyc, m_level, m_lead, m_trail, m_run, m_mode, m_cyc);
         end
      end
      checks++;
      if (cyc !== CYC_W'(CYC_MAX)) begin
         errors++;
         $display("FAIL cyc_saturated: got %0d required %0d", cyc, CYC_MAX);
      end
      en = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (!busy) found = 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL stop_timeout: busy got 1 required 0"); end
      step();
      en = 1'b1;
      step();
      step();
      checks++;
      if ({busy, cyc} !== {1'b1, CYC_W'(0)}) begin
         errors++;
         $display("FAIL cyc_restart: busy/cyc got %b/%0d required 1/0", busy, cyc);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 3) en = ~en;
         if ($urandom_range(0, 99) < 2) sel = ~sel;
         ld  = ($urandom_range(0, 99) < 4);
         tgt = 1'($urandom_range(0, 1));
         val = CNT_W'($urandom_range(0, 5));
         step();
         checks++;
         if ({sclk, lead, trail, busy, mode, cyc} !== {m_level, m_lead, m_trail, m_run, m_mode, CYC_W'(m_cyc)}) begin
            errors++;
            $display("FAIL random edge %0d: got %b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
                     n, sclk, lead, trail, busy, mode, cyc, m_level, m_lead, m_trail, m_run, m_mode, m_cyc);
         end
      end
      ld = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit found;
      int last;
      // make sure init divider holds a non-default value before the reset
      ld = 1'b1; tgt = 1'b0; val = CNT_W'(4);
      step();
      ld = 1'b1; tgt = 1'b1; val = CNT_W'(5);
      step();
      ld = 1'b0;
      en = 1'b1;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (lead) found = 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL reset_mid_lead_timeout: got none required lead tick"); end
      step();
      #2 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({sclk, lead, trail, busy, mode, cyc} !== {CPOL, 1'b0, 1'b0, 1'b0, 1'b0, CYC_W'(0)}) begin
         errors++;
         $display("FAIL reset_async: sclk/lead/trail/busy/mode/cyc got %b/%b/%b/%b/%b/%0d required %b/0/0/0/0/0",
                  sclk, lead, trail, busy, mode, cyc, CPOL);
      end
      @(posedge clk); #1;
      checks++;
      if ({sclk, trail} !== {CPOL, 1'b0}) begin
         errors++;
         $display("FAIL reset_no_trail: sclk/trail got %b/%b required %b/0", sclk, trail, CPOL);
      end
      rst = 1'b0;
      en = 1'b1; sel = 1'b0;
      last = int'(n) + 1;
      for (int i = 0; i < 600; i++) begin
         step();
         checks++;
         if ({sclk, lead, trail, busy, mode, cyc} !== {m_level, m_lead, m_trail, m_run, m_mode, CYC_W'(m_cyc)}) begin
            errors++;
            $display("FAIL post_reset_init edge %0d: got %b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
                     n, sclk, lead, trail, busy, mode, cyc, m_level, m_lead, m_trail, m_run, m_mode, m_cyc);
         end
         if (lead || trail) begin
            checks++;
            if (int'(n) - last != int'(INIT_DIV) + 1) begin
               errors++;
               $display("FAIL post_reset_init_gap edge %0d: got %0d required %0d", n, int'(n) - last, INIT_DIV + 1);
            end
            last = int'(n);
         end
      end
      en = 1'b0;
      found = 0;
      for (int i = 0; i < 600 && !found; i++) begin
         step();
         if (!busy) found = 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL post_reset_stop_timeout: busy got 1 required 0"); end
      step();
      en = 1'b1; sel = 1'b1;
      last = int'(n) + 1;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if ({sclk, lead, trail, busy, mode, cyc} !== {m_level, m_lead, m_trail, m_run, m_mode, CYC_W'(m_cyc)}) begin
            errors++;
            $display("FAIL post_reset_normal edge %0d: got %b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
                     n, sclk, lead, trail, busy, mode, cyc, m_level, m_lead, m_trail, m_run, m_mode, m_cyc);
         end
         if (lead || trail) begin
            checks++;
            if (int'(n) - last != int'(NORM_DIV) + 1) begin
               errors++;
               $display("FAIL post_reset_normal_gap edge %0d: got %0d required %0d", n, int'(n) - last, NORM_DIV + 1);
            end
            last = int'(n);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_init_mode();
      test_mode_switch();
      test_div_load_zero();
      test_disable();
      test_saturation();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
